// File: rtl/gshare_predictor_v2.sv
// Gshare direction predictor: PC^GHR-indexed PHT of saturating counters, speculative GHR with mispredict repair.
// Prediction 1 cycle after request; no backpressure, but requests and updates are dropped while init_busy is high.
module gshare_predictor_v2 #(
    parameter int INDEX_BITS = 13,
    parameter int GHR_WIDTH  = 13,
    parameter int CTR_BITS   = 2,
    parameter int PC_LSB     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pred_valid,
    input  logic [31:0]          pred_pc,
    output logic                 pred_out_valid,
    output logic                 prediction,
    output logic [GHR_WIDTH-1:0] pred_ghr,
    input  logic                 update_en,
    input  logic [31:0]          update_pc,
    input  logic [GHR_WIDTH-1:0] update_ghr_val,
    input  logic                 actual_taken,
    input  logic                 mispredict,
    output logic                 init_busy
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_MIN  = '0;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                 state_q, state_d;
    logic [INDEX_BITS-1:0]  sweep_q, sweep_d;
    logic [GHR_WIDTH-1:0]   spec_ghr_q, spec_ghr_d;
    logic [GHR_WIDTH-1:0]   pred_ghr_q;
    logic                   prediction_q;
    logic                   pred_out_valid_q;
    logic [CTR_BITS-1:0]    pht_q [ENTRIES];

    logic                   run;
    logic                   pred_acc;
    logic                   upd_acc;
    logic [INDEX_BITS-1:0]  pred_idx;
    logic [INDEX_BITS-1:0]  upd_idx;
    logic [CTR_BITS-1:0]    pred_ctr;
    logic [CTR_BITS-1:0]    upd_ctr;
    logic                   pred_dir;
    logic                   pht_we;
    logic [INDEX_BITS-1:0]  pht_widx;
    logic [CTR_BITS-1:0]    pht_wdat;
    logic                   unused_pc_bits;

    assign unused_pc_bits = ^{pred_pc, update_pc};

    assign run      = (state_q == ST_RUN);
    assign pred_acc = pred_valid & run;
    assign upd_acc  = update_en & run;

    assign pred_idx = pred_pc[PC_LSB +: INDEX_BITS] ^ INDEX_BITS'(spec_ghr_q);
    assign upd_idx  = update_pc[PC_LSB +: INDEX_BITS] ^ INDEX_BITS'(update_ghr_val);

    // Combinational read of the current array gives read-old on a same-index update.
    assign pred_ctr = pht_q[pred_idx];
    assign upd_ctr  = pht_q[upd_idx];
    assign pred_dir = pred_ctr[CTR_BITS-1];

    always_comb begin
        state_d  = state_q;
        sweep_d  = sweep_q;
        pht_we   = 1'b0;
        pht_widx = upd_idx;
        pht_wdat = upd_ctr;
        case (state_q)
            ST_INIT: begin
                pht_we   = 1'b1;
                pht_widx = sweep_q;
                pht_wdat = CTR_INIT;
                sweep_d  = sweep_q + 1'b1;
                if (sweep_q == '1) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (update_en) begin
                    pht_we = 1'b1;
                    if (actual_taken) begin
                        pht_wdat = (upd_ctr == CTR_MAX) ? upd_ctr : upd_ctr + 1'b1;
                    end else begin
                        pht_wdat = (upd_ctr == CTR_MIN) ? upd_ctr : upd_ctr - 1'b1;
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Mispredict repair takes priority over the speculative shift.
    always_comb begin
        spec_ghr_d = spec_ghr_q;
        if (pred_acc) begin
            spec_ghr_d = {spec_ghr_q[GHR_WIDTH-2:0], pred_dir};
        end
        if (upd_acc && mispredict) begin
            spec_ghr_d = {update_ghr_val[GHR_WIDTH-2:0], actual_taken};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_INIT;
            sweep_q          <= '0;
            spec_ghr_q       <= '0;
            pred_ghr_q       <= '0;
            prediction_q     <= 1'b0;
            pred_out_valid_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            sweep_q          <= sweep_d;
            spec_ghr_q       <= spec_ghr_d;
            pred_out_valid_q <= pred_acc;
            if (pred_acc) begin
                prediction_q <= pred_dir;
                pred_ghr_q   <= spec_ghr_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pht_we && !rst) begin
            pht_q[pht_widx] <= pht_wdat;
        end
    end

    assign pred_out_valid = pred_out_valid_q;
    assign prediction     = prediction_q;
    assign pred_ghr       = pred_ghr_q;
    assign init_busy      = (state_q == ST_INIT);

endmodule

// File: tb/tb_gshare_predictor_v2.sv
// Directed bench for gshare_predictor_v2 at default parameters (13/13/2/2).
module tb_gshare_predictor_v2;

    logic        clk = 1'b0;
    logic        rst;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_out_valid;
    logic        prediction;
    logic [12:0] pred_ghr;
    logic        update_en;
    logic [31:0] update_pc;
    logic [12:0] update_ghr_val;
    logic        actual_taken;
    logic        mispredict;
    logic        init_busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    gshare_predictor_v2 dut (
        .clk            (clk),
        .rst            (rst),
        .pred_valid     (pred_valid),
        .pred_pc        (pred_pc),
        .pred_out_valid (pred_out_valid),
        .prediction     (prediction),
        .pred_ghr       (pred_ghr),
        .update_en      (update_en),
        .update_pc      (update_pc),
        .update_ghr_val (update_ghr_val),
        .actual_taken   (actual_taken),
        .mispredict     (mispredict),
        .init_busy      (init_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic count_init(output int cycles, output bit saw_vld);
        cycles  = 0;
        saw_vld = 1'b0;
        while (init_busy === 1'b1 && cycles < 10000) begin
            if (pred_out_valid !== 1'b0) saw_vld = 1'b1;
            cycles++;
            tick();
        end
    endtask

    int          cyc;
    bit          saw;
    logic [31:0] rec_pc  [3];
    logic [31:0] rec_ghr [3];

    initial begin
        rst = 1'b1; pred_valid = 1'b0; pred_pc = '0; update_en = 1'b0; update_pc = '0;
        update_ghr_val = '0; actual_taken = 1'b0; mispredict = 1'b0;
        rec_pc[0] = 32'h100; rec_ghr[0] = 32'h0;
        rec_pc[1] = 32'h104; rec_ghr[1] = 32'h1;
        rec_pc[2] = 32'h10C; rec_ghr[2] = 32'h3;

        repeat (3) tick();
        check("rst_init_busy", 32'(init_busy), 32'h1);
        check("rst_pred_vld", 32'(pred_out_valid), 32'h0);
        check("rst_prediction", 32'(prediction), 32'h0);
        check("rst_pred_ghr", 32'(pred_ghr), 32'h0);

        // Requests and updates held high through INIT must be ignored.
        rst = 1'b0;
        pred_valid = 1'b1; pred_pc = 32'h100;
        update_en = 1'b1; update_pc = 32'h100; update_ghr_val = '0; actual_taken = 1'b1; mispredict = 1'b1;
        count_init(cyc, saw);
        pred_valid = 1'b0; update_en = 1'b0; mispredict = 1'b0;
        check("init_len", 32'(cyc), 32'd8192);
        check("init_no_pred_vld", 32'(saw), 32'h0);
        check("init_ghr_hold", 32'(dut.spec_ghr_q), 32'h0);
        check("init_upd_ignored", 32'(dut.pht_q[13'h040]), 32'h1);
        check("init_last_entry", 32'(dut.pht_q[13'h1FFF]), 32'h1);

        pred_valid = 1'b1; pred_pc = 32'h100;
        tick();
        pred_valid = 1'b0;
        check("first_pred_vld", 32'(pred_out_valid), 32'h1);
        check("first_pred", 32'(prediction), 32'h0);
        check("first_pred_ghr", 32'(pred_ghr), 32'h0);
        tick();
        check("pred_vld_drop", 32'(pred_out_valid), 32'h0);

        update_en = 1'b1; update_pc = 32'h100; update_ghr_val = '0; actual_taken = 1'b1;
        repeat (2) tick();
        update_en = 1'b0;
        check("train_entry", 32'(dut.pht_q[13'h040]), 32'h3);
        pred_valid = 1'b1; pred_pc = 32'h100;
        tick();
        pred_valid = 1'b0;
        check("train_vld", 32'(pred_out_valid), 32'h1);
        check("train_pred", 32'(prediction), 32'h1);
        check("train_pred_ghr", 32'(pred_ghr), 32'h0);
        check("train_spec_ghr", 32'(dut.spec_ghr_q), 32'h1);

        update_en = 1'b1; update_pc = 32'h200; update_ghr_val = '0; actual_taken = 1'b1;
        repeat (5) tick();
        check("sat_hi", 32'(dut.pht_q[13'h080]), 32'h3);
        actual_taken = 1'b0;
        tick();
        check("sat_dec1", 32'(dut.pht_q[13'h080]), 32'h2);
        repeat (3) tick();
        check("sat_dec4", 32'(dut.pht_q[13'h080]), 32'h0);
        tick();
        check("sat_lo", 32'(dut.pht_q[13'h080]), 32'h0);
        update_en = 1'b0;

        // Repair-only update to bring spec_ghr back to zero.
        update_en = 1'b1; mispredict = 1'b1; update_pc = 32'h300; update_ghr_val = '0; actual_taken = 1'b0;
        tick();
        update_en = 1'b0; mispredict = 1'b0;
        check("repair_ghr0", 32'(dut.spec_ghr_q), 32'h0);
        check("repair_entry", 32'(dut.pht_q[13'h0C0]), 32'h0);

        // Each PC XOR the running history lands on strongly-taken entry 0x040.
        for (int i = 0; i < 3; i++) begin
            pred_valid = 1'b1; pred_pc = rec_pc[i];
            tick();
            check("rec_pred", 32'(prediction), 32'h1);
            check("rec_pred_ghr", 32'(pred_ghr), rec_ghr[i]);
        end
        pred_valid = 1'b0;
        check("rec_spec7", 32'(dut.spec_ghr_q), 32'h7);

        pred_valid = 1'b1; pred_pc = 32'h100;
        update_en = 1'b1; mispredict = 1'b1; update_pc = 32'h400; update_ghr_val = 13'h1; actual_taken = 1'b0;
        tick();
        pred_valid = 1'b0; update_en = 1'b0; mispredict = 1'b0;
        check("rec_override", 32'(dut.spec_ghr_q), 32'h2);
        check("rec_same_vld", 32'(pred_out_valid), 32'h1);
        check("rec_same_pred", 32'(prediction), 32'h0);
        check("rec_same_ghr", 32'(pred_ghr), 32'h7);
        check("rec_upd_entry", 32'(dut.pht_q[13'h101]), 32'h0);

        check("rdold_pre", 32'(dut.pht_q[13'h050]), 32'h1);
        pred_valid = 1'b1; pred_pc = 32'h148;
        update_en = 1'b1; update_pc = 32'h140; update_ghr_val = '0; actual_taken = 1'b1;
        tick();
        pred_valid = 1'b0; update_en = 1'b0;
        check("rdold_pred", 32'(prediction), 32'h0);
        check("rdold_entry", 32'(dut.pht_q[13'h050]), 32'h2);
        check("rdold_spec", 32'(dut.spec_ghr_q), 32'h4);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rrst_vld", 32'(pred_out_valid), 32'h0);
        check("rrst_pred_ghr", 32'(pred_ghr), 32'h0);
        check("rrst_spec", 32'(dut.spec_ghr_q), 32'h0);
        check("rrst_busy", 32'(init_busy), 32'h1);
        repeat (4000) tick();
        check("mid_busy", 32'(init_busy), 32'h1);
        check("mid_entry40", 32'(dut.pht_q[13'h040]), 32'h1);
        check("mid_entry80", 32'(dut.pht_q[13'h080]), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_init(cyc, saw);
        check("mid_init_len", 32'(cyc), 32'd8192);
        check("mid_entry80_after", 32'(dut.pht_q[13'h080]), 32'h1);
        check("mid_entry50_after", 32'(dut.pht_q[13'h050]), 32'h1);

        pred_valid = 1'b1; pred_pc = 32'h200;
        tick();
        pred_valid = 1'b0;
        check("final_vld", 32'(pred_out_valid), 32'h1);
        check("final_pred", 32'(prediction), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
